seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 39 +++
 rtl/seq_alu_muldiv.sv | 87 ++++++++
 rtl/seq_alu.sv | 157 +++++++++++++++
 tb/tb_seq_alu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared op codes, FSM state encoding and helpers for seq_alu
//
// Purpose: single source of truth for the 4-bit op-select encoding and the
//          IDLE/BUSY/DONE state type used by seq_alu and seq_alu_muldiv.
// Ports:   none (package).
package seq_alu_pkg;

   localparam int OP_BITS = 4;

   localparam logic [OP_BITS-1:0] OP_ADD  = 4'h0;
   localparam logic [OP_BITS-1:0] OP_SUB  = 4'h1;
   localparam logic [OP_BITS-1:0] OP_MUL  = 4'h2;
   localparam logic [OP_BITS-1:0] OP_DIV  = 4'h3;
   localparam logic [OP_BITS-1:0] OP_SHL  = 4'h4;
   localparam logic [OP_BITS-1:0] OP_SHR  = 4'h5;
   localparam logic [OP_BITS-1:0] OP_ROL  = 4'h6;
   localparam logic [OP_BITS-1:0] OP_ROR  = 4'h7;
   localparam logic [OP_BITS-1:0] OP_AND  = 4'h8;
   localparam logic [OP_BITS-1:0] OP_OR   = 4'h9;
   localparam logic [OP_BITS-1:0] OP_XOR  = 4'hA;
   localparam logic [OP_BITS-1:0] OP_NOR  = 4'hB;
   localparam logic [OP_BITS-1:0] OP_NAND = 4'hC;
   localparam logic [OP_BITS-1:0] OP_XNOR = 4'hD;
   localparam logic [OP_BITS-1:0] OP_GT   = 4'hE;
   localparam logic [OP_BITS-1:0] OP_EQ   = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ops that need the iterative datapath; DIV by zero short-circuits.
   function automatic logic is_iterative(input logic [OP_BITS-1:0] op,
                                         input logic b_nonzero);
      return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// rtl/seq_alu_muldiv.sv - iterative shift-add multiplier and restoring divider
//
// Purpose: one multiply or divide step per clock after start; WIDTH steps total.
//          done is high during the last step; res/ovf are that step's outcome
//          (combinational) so the caller can register them on the same edge.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          start             - load operands (one cycle, only while idle)
//          op                - OP_MUL or OP_DIV, sampled on start
//          a, b              - operands, sampled on start
//          done              - final step in progress
//          res               - low product bits or quotient
//          ovf               - MUL only: high product bits nonzero
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [OP_BITS-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [WIDTH-1:0]   res,
   output logic               ovf
);

   localparam int CW = $clog2(WIDTH);

   logic               run;
   logic               is_div;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   x;        // multiplicand (MUL) or divisor (DIV)
   logic [2*WIDTH-1:0] p;        // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] p_next;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;

   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      p_next  = p;
      if (is_div) begin
         // Shift next dividend bit into the remainder; keep the subtraction
         // only if it did not borrow (bit WIDTH clear).
         shifted = p[2*WIDTH-1:WIDTH-1];
         diff    = shifted - {1'b0, x};
         if (!diff[WIDTH])
            p_next = {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
         else
            p_next = {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      end else begin
         // LSB-first shift-add: the add carry lands in the top bit.
         sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, x} : '0);
         p_next = {sum, p[WIDTH-1:1]};
      end
   end

   assign done = run && (cnt == CW'(WIDTH - 1));
   assign res  = p_next[WIDTH-1:0];
   assign ovf  = !is_div && (|p_next[2*WIDTH-1:WIDTH]);

   always_ff @(posedge clk) begin
      if (rst) begin
         run    <= 1'b0;
         is_div <= 1'b0;
         cnt    <= '0;
         x      <= '0;
         p      <= '0;
      end else if (start) begin
         run    <= 1'b1;
         cnt    <= '0;
         is_div <= (op == OP_DIV);
         x      <= (op == OP_DIV) ? b : a;
         p      <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? a : b)};
      end else if (run) begin
         p   <= p_next;
         cnt <= cnt + 1'b1;
         if (done)
            run <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake and optional iterative MUL/DIV
//
// Purpose: accepts one op per handshake, returns a registered result and flags.
//          Single-cycle ops finish on the accept edge; MUL and DIV (b != 0) run
//          WIDTH extra cycles in seq_alu_muldiv when SEQ_ALU_MULDIV_EN is defined.
//          Without SEQ_ALU_MULDIV_EN, MUL/DIV finish single-cycle with all-zero outputs.
// Ports:   clk, rst               - clock, synchronous active-high reset
//          in_valid, in_ready     - request handshake
//          a, b, op               - operands and op select, captured on accept
//          out_valid, out_ready   - response handshake
//          result                 - registered result
//          carry                  - carry / borrow / multiply overflow
//          zero                   - result == 0
//          div_by_zero            - DIV issued with b == 0
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             div_by_zero
);

   state_t           state;
   logic             accept;
   logic             go_busy;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry;
   logic             sc_dz;
   logic [WIDTH:0]   wide;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_dz    = 1'b0;
      wide     = '0;
      case (op)
         OP_ADD: begin
            wide     = {1'b0, a} + {1'b0, b};
            sc_res   = wide[WIDTH-1:0];
            sc_carry = wide[WIDTH];
         end
         OP_SUB: begin
            sc_res   = a - b;
            sc_carry = (a < b);
         end
         OP_MUL:  sc_res = '0;
         OP_DIV: begin
`ifdef SEQ_ALU_MULDIV_EN
            // Only the divide-by-zero case reaches the single-cycle path.
            if (b == '0) begin
               sc_res = '1;
               sc_dz  = 1'b1;
            end
`else
            sc_res = '0;
`endif
         end
         OP_SHL:  sc_res = {a[WIDTH-2:0], 1'b0};
         OP_SHR:  sc_res = {1'b0, a[WIDTH-1:1]};
         OP_ROL:  sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
         OP_ROR:  sc_res = {a[0], a[WIDTH-1:1]};
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_NOR:  sc_res = ~(a | b);
         OP_NAND: sc_res = ~(a & b);
         OP_XNOR: sc_res = ~(a ^ b);
         OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
         default: sc_res = '0;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   logic             md_done;
   logic [WIDTH-1:0] md_res;
   logic             md_ovf;

   assign go_busy = is_iterative(op, |b);

   seq_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (accept && go_busy),
      .op    (op),
      .a     (a),
      .b     (b),
      .done  (md_done),
      .res   (md_res),
      .ovf   (md_ovf)
   );
`else
   assign go_busy = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         result      <= '0;
         carry       <= 1'b0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  if (go_busy) begin
                     state <= BUSY;
                  end else begin
                     state       <= DONE;
                     result      <= sc_res;
                     carry       <= sc_carry;
                     zero        <= (sc_res == '0);
                     div_by_zero <= sc_dz;
                  end
               end else if ((state == DONE) && out_ready) begin
                  state <= IDLE;
               end
            end
            BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
               if (md_done) begin
                  state       <= DONE;
                  result      <= md_res;
                  carry       <= md_ovf;
                  zero        <= (md_res == '0);
                  div_by_zero <= 1'b0;
               end
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W = 16;
`ifdef SEQ_ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int LAT_IT = MD ? W + 1 : 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         div_by_zero;

   int   errors = 0;
   int   checks = 0;
   int   lat;
   logic busy_rdy;
   logic seen;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W), .OPW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .carry       (carry),
      .zero        (zero),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, then count edges (acceptance edge = 1) until out_valid.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      busy_rdy = 1'b0;
      while (!out_valid && lat < 100) begin
         busy_rdy = busy_rdy | in_ready;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   logic [3:0]   v_op [17];
   logic [W-1:0] v_a  [17];
   logic [W-1:0] v_b  [17];
   logic [W-1:0] v_r  [17];
   logic         v_c  [17];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      v_op = '{OP_SUB, OP_SUB, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_AND, OP_OR, OP_XOR,
               OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_GT, OP_GT, OP_EQ, OP_EQ};
      v_a  = '{16'h000A, 16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hF0F0, 16'hF0F0, 16'hF0F0,
               16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0005, 16'h0003, 16'h0005, 16'h0007, 16'h0007};
      v_b  = '{16'h0003, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'hFF00, 16'hFF00,
               16'hFF00, 16'hFF00, 16'hFF00, 16'h0003, 16'h0005, 16'h0005, 16'h0007, 16'h0008};
      v_r  = '{16'h0007, 16'hFFFF, 16'h0002, 16'h4000, 16'h0003, 16'hC000, 16'hF000, 16'hFFF0, 16'h0FF0,
               16'h000F, 16'h0FFF, 16'hF00F, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
      v_c  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_carry", carry, 0);
      chk("rst_zero", zero, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;

      issue(OP_ADD, 16'hFFFF, 16'h0001);
      chk("add_lat", lat, 1);
      chk("add_res", result, 16'h0000);
      chk("add_carry", carry, 1);
      chk("add_zero", zero, 1);
      chk("add_dbz", div_by_zero, 0);

      issue(OP_ADD, 16'h1234, 16'h4321);
      chk("add2_res", result, 16'h5555);
      chk("add2_carry", carry, 0);
      chk("add2_zero", zero, 0);

      issue(OP_DIV, 16'd100, 16'd7);
      chk("div_lat", lat, LAT_IT);
      chk("div_res", result, MD ? 16'd14 : 16'd0);
      chk("div_busy_ready", busy_rdy, 0);
      chk("div_carry", carry, 0);
      chk("div_dbz", div_by_zero, 0);

      issue(OP_DIV, 16'h1234, 16'h0000);
      chk("dbz_lat", lat, 1);
      chk("dbz_res", result, MD ? 16'hFFFF : 16'h0000);
      chk("dbz_flag", div_by_zero, MD ? 1 : 0);
      chk("dbz_carry", carry, 0);
      chk("dbz_zero", zero, MD ? 0 : 1);

      issue(OP_MUL, 16'h0100, 16'h0100);
      chk("mul_lat", lat, LAT_IT);
      chk("mul_res", result, 16'h0000);
      chk("mul_carry", carry, MD ? 1 : 0);
      chk("mul_zero", zero, 1);
      chk("mul_dbz", div_by_zero, 0);

      issue(OP_MUL, 16'h1234, 16'h0003);
      chk("mul2_res", result, MD ? 16'h369C : 16'h0000);
      chk("mul2_carry", carry, 0);

      issue(OP_MUL, 16'hFFFF, 16'hFFFF);
      chk("mul3_res", result, MD ? 16'h0001 : 16'h0000);
      chk("mul3_carry", carry, MD ? 1 : 0);

      issue(OP_DIV, 16'hFFFF, 16'h0001);
      chk("div2_res", result, MD ? 16'hFFFF : 16'h0000);
      chk("div2_dbz", div_by_zero, 0);

      issue(OP_DIV, 16'd5, 16'd9);
      chk("div3_res", result, 16'h0000);
      chk("div3_zero", zero, 1);
      chk("div3_lat", lat, LAT_IT);

      for (int i = 0; i < 17; i++) begin
         issue(v_op[i], v_a[i], v_b[i]);
         chk($sformatf("vec%0d_lat", i), lat, 1);
         chk($sformatf("vec%0d_res", i), result, v_r[i]);
         chk($sformatf("vec%0d_carry", i), carry, v_c[i]);
         chk($sformatf("vec%0d_zero", i), zero, (v_r[i] == '0) ? 1 : 0);
      end

      // Backpressure: result must hold while out_ready is low.
      @(posedge clk);
      #1;
      chk("idle_after_ready", out_valid, 0);
      out_ready = 1'b0;
      issue(OP_SUB, 16'd3, 16'd5);
      chk("sub_res", result, 16'hFFFE);
      chk("sub_carry", carry, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d_valid", i), out_valid, 1);
         chk($sformatf("hold%0d_res", i), result, 16'hFFFE);
         chk($sformatf("hold%0d_carry", i), carry, 1);
         chk($sformatf("hold%0d_ready", i), in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = OP_ADD; a = 16'd2; b = 16'd3;
      #1;
      chk("ready_on_out_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_res", result, 16'd5);
      chk("b2b_carry", carry, 0);
      @(posedge clk);
      #1;
      chk("b2b_idle", out_valid, 0);

      // Reset during BUSY cycle 8 of a DIV.
      @(negedge clk);
      in_valid = 1'b1;
      op = OP_DIV; a = 16'd100; b = 16'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("busy8_valid", out_valid, 0);
      chk("busy8_ready", in_ready, MD ? 0 : 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 1);
      chk("abort_res", result, 0);
      chk("abort_carry", carry, 0);
      chk("abort_zero", zero, 0);
      chk("abort_dbz", div_by_zero, 0);
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      chk("abort_no_result", seen, 0);

      issue(OP_ADD, 16'd1, 16'd1);
      chk("post_rst_lat", lat, 1);
      chk("post_rst_res", result, 16'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
